cell_pingpong_buffer: RTL and testbench
=======================================

Name: cell_pingpong_buffer

Overview:
- Double-banked per-cell position store for the motion-update path.
- The active bank serves reads (random or streamed) to the force pipeline. The shadow bank accepts append-writes of updated particle positions.
- A swap command exchanges the two banks and logically empties the new shadow bank.
- One instance per cell. Each bank is an inferred single-port synchronous RAM with registered output, plus a per-bank particle counter.

Parameters:
- DATA_WIDTH, 96, particle record width {posz, posy, posx}
- PARTICLE_NUM, 220, max particles per bank; must be ≤ 2**ADDR_WIDTH
- ADDR_WIDTH, 8, word address width
- CNT_WIDTH, ADDR_WIDTH+1, counter width

Ports:
- clock  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  random read request on the active bank (ignored while streaming)
- rd_addr  in  ADDR_WIDTH  random read address
- stream_start  in  1  pulse: stream the whole active bank from address 0
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data valid
- rd_last  out  1  final beat of a stream
- stream_busy  out  1  stream in progress
- stream_done  out  1  one-cycle pulse at stream completion
- wr_en  in  1  append wr_data to the shadow bank
- wr_data  in  DATA_WIDTH  particle record
- wr_full  out  1  shadow count == PARTICLE_NUM
- wr_overflow  out  1  sticky: write attempted while full
- swap_req  in  1  pulse: request a bank swap
- swap_ack  out  1  one-cycle pulse when the swap is executed
- active_count  out  CNT_WIDTH  particles in the active bank
- shadow_count  out  CNT_WIDTH  particles in the shadow bank

Behaviour:
- Reset values (async, rst_n low):
  - bank select = 0 (bank0 active); both counts 0; FSM IDLE; swap-pending flag 0.
  - rd_data = 0; all flags and pulses 0.
  - RAM contents are not reset.
- Random read: rd_en in IDLE at cycle N gives rd_data/rd_valid at N+1 (1-cycle latency). rd_addr ≥ active_count still reads RAM; contents are undefined.
- FSM states:
  - IDLE: on stream_start, go to STREAM with ptr=0. If active_count==0, stay in IDLE and pulse stream_done at N+1 with no beats.
  - STREAM: issue one read per cycle, ptr=0..active_count−1. Beats appear 1 cycle after issue. rd_last accompanies beat active_count−1. stream_done pulses with rd_last. stream_busy is high from the cycle after stream_start through the rd_last cycle. Return to IDLE after rd_last.
- stream_start while in STREAM: ignored. rd_en while in STREAM: ignored, no rd_valid generated for it.
- Append write:
  - wr_en and !wr_full writes shadow[shadow_count], then shadow_count increments.
  - wr_en and wr_full: no write, count unchanged, wr_overflow set.
  - wr_overflow clears only on reset or swap.
- Swap:
  - swap_req sets the pending flag.
  - The swap executes on the first cycle where pending and FSM==IDLE and no stream_start is present that cycle. Effect at that edge:
    - bank select toggles.
    - active_count takes the old shadow_count, including any wr_en accepted in the same cycle.
    - shadow_count becomes 0 and wr_overflow becomes 0.
    - swap_ack pulses in the following cycle.
  - A swap_req during STREAM is deferred until after rd_last. Multiple swap_req pulses while pending collapse to one swap.
- Simultaneous events:
  - wr_en in the same cycle as the swap edge: the write lands in the old shadow bank and is counted into the new active_count.
  - rd_en in the swap cycle reads the old active bank.
- Write and read target different banks, so no read-during-write hazard exists.

Test Plan:
- Reset, then 3 appends (A,B,C), swap_req → swap_ack 1 cycle after execution, active_count=3, shadow_count=0; stream_start → beats A,B,C on 3 consecutive cycles, rd_last and stream_done on C, stream_busy low afterwards.
- 220 appends, then 1 more → wr_full=1 after the 220th, shadow_count stays 220, wr_overflow=1; swap → wr_overflow=0, active_count=220.
- swap_req at beat 1 of a 5-particle stream → all 5 beats come from the old bank, then swap executes and swap_ack pulses 1 cycle after rd_last.
- wr_en(D) in the same cycle as swap execution with shadow_count=2 → active_count=3; random read addr 2 gives D one cycle later.
- stream_start with active_count=0 → no rd_valid; stream_done pulses next cycle.
- rst_n low mid-stream → all outputs 0 immediately, counts 0; after release, rd_valid stays 0 until a new request.

Source files
------------

// File: rtl/cell_pingpong_buffer.sv
// cell_pingpong_buffer: double-banked per-cell particle position store
//
// One bank (active) serves random or streamed reads; the other (shadow)
// takes append-writes. A swap exchanges the banks and empties the new shadow.
//
// Ports:
//   clock, rst_n               clock (rising edge), async active-low reset
//   rd_en, rd_addr             random read of the active bank (IDLE only)
//   stream_start               stream the whole active bank from address 0
//   rd_data, rd_valid, rd_last read beat, valid, final stream beat
//   stream_busy, stream_done   stream in progress / completion pulse
//   wr_en, wr_data             append a record to the shadow bank
//   wr_full, wr_overflow       shadow full / sticky write-while-full
//   swap_req, swap_ack         swap request / pulse after swap executed
//   active_count, shadow_count particles held in each bank
module cell_pingpong_buffer #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int CNT_WIDTH    = ADDR_WIDTH + 1
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  stream_start,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  stream_busy,
   output logic                  stream_done,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic                  wr_overflow,
   input  logic                  swap_req,
   output logic                  swap_ack,
   output logic [CNT_WIDTH-1:0]  active_count,
   output logic [CNT_WIDTH-1:0]  shadow_count
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   typedef enum logic {IDLE, STREAM} state_e;
   state_e                state_q, state_d;
   logic                  sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]  act_cnt_q, act_cnt_d;
   logic [CNT_WIDTH-1:0]  shd_cnt_q, shd_cnt_d;
   logic                  pend_q, pend_d;
   logic                  ovf_q, ovf_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_last_q, rd_last_d;
   logic                  done_q, done_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] mem0 [DEPTH];
   logic [DATA_WIDTH-1:0] mem1 [DEPTH];
   logic                  full, wr_ok, do_swap, rd_fire, last_issue;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   assign full        = shd_cnt_q == CNT_WIDTH'(PARTICLE_NUM);
   assign wr_ok       = wr_en && !full;
   // swap only when no stream is running or about to start this cycle
   assign do_swap     = pend_q && state_q == IDLE && !stream_start;
   assign rd_fire     = state_q == STREAM || rd_en;
   assign rd_ptr      = state_q == STREAM ? ptr_q : rd_addr;
   assign last_issue  = state_q == STREAM && CNT_WIDTH'(ptr_q) == act_cnt_q - CNT_WIDTH'(1);
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      done_d     = 1'b0;
      rd_valid_d = rd_fire;
      rd_last_d  = last_issue;
      case (state_q)
         IDLE: begin
            if (stream_start) begin
               if (act_cnt_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = STREAM;
                  ptr_d   = '0;
               end
            end
         end
         STREAM: begin
            ptr_d  = ptr_q + 1'b1;
            done_d = last_issue;
            if (last_issue) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      sel_d     = sel_q ^ do_swap;
      pend_d    = do_swap ? 1'b0 : (pend_q || swap_req);
      ack_d     = do_swap;
      // a write accepted in the swap cycle still counts toward the new active bank
      act_cnt_d = do_swap ? shd_cnt_q + CNT_WIDTH'(wr_ok) : act_cnt_q;
      shd_cnt_d = do_swap ? '0 : shd_cnt_q + CNT_WIDTH'(wr_ok);
      ovf_d     = do_swap ? 1'b0 : (ovf_q || (wr_en && full));
   end
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         ptr_q      <= '0;
         act_cnt_q  <= '0;
         shd_cnt_q  <= '0;
         pend_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         done_q     <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         act_cnt_q  <= act_cnt_d;
         shd_cnt_q  <= shd_cnt_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         done_q     <= done_d;
         ack_q      <= ack_d;
      end
   end
   // shadow bank is the one not selected for reads
   always_ff @(posedge clock) begin
      if (wr_ok && sel_q) mem0[shd_cnt_q[ADDR_WIDTH-1:0]] <= wr_data;
      if (wr_ok && !sel_q) mem1[shd_cnt_q[ADDR_WIDTH-1:0]] <= wr_data;
   end
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else if (rd_fire) rd_data_q <= sel_q ? mem1[rd_ptr] : mem0[rd_ptr];
   end
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign rd_last      = rd_last_q;
   // the final beat arrives after the FSM has already returned to IDLE
   assign stream_busy  = state_q == STREAM || rd_last_q;
   assign stream_done  = done_q;
   assign wr_full      = full;
   assign wr_overflow  = ovf_q;
   assign swap_ack     = ack_q;
   assign active_count = act_cnt_q;
   assign shadow_count = shd_cnt_q;
endmodule

// File: tb/tb_cell_pingpong_buffer.sv
// tb_cell_pingpong_buffer: scoreboard bench for cell_pingpong_buffer
module tb_cell_pingpong_buffer;
   localparam int DW = 96;
   localparam int PN = 220;
   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_en = 1'b0;
   logic [7:0]    rd_addr = '0;
   logic          stream_start = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, rd_last, stream_busy, stream_done;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_full, wr_overflow;
   logic          swap_req = 1'b0;
   logic          swap_ack;
   logic [8:0]    active_count, shadow_count;
   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;
   exp_t          sb[$];
   logic [DW-1:0] act_m [256];
   logic [DW-1:0] shd_m [256];
   int            act_n = 0;
   int            shd_n = 0;
   int            checks = 0;
   int            failures = 0;
   cell_pingpong_buffer dut (
      .clock(clock), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
      .stream_start(stream_start), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_last(rd_last), .stream_busy(stream_busy), .stream_done(stream_done),
      .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_overflow(wr_overflow),
      .swap_req(swap_req), .swap_ack(swap_ack), .active_count(active_count),
      .shadow_count(shadow_count)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clock) begin
      if (rst_n && rd_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rd_valid", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_data", rd_data, e.d);
            chk("rd_last", rd_last, e.l);
         end
      end
   end
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom, $urandom};
   endfunction
   task automatic model_append(input logic [DW-1:0] d);
      if (shd_n < PN) begin
         shd_m[shd_n] = d;
         shd_n++;
      end
   endtask
   task automatic model_swap();
      act_m = shd_m;
      act_n = shd_n;
      shd_n = 0;
   endtask
   task automatic write(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      model_append(d);
      chk("shadow_count", shadow_count, DW'(shd_n));
   endtask
   task automatic swap(input logic with_w, input logic [DW-1:0] d);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      chk("ack_early", swap_ack, 1'b0);
      wr_en   = with_w;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (with_w) model_append(d);
      model_swap();
      chk("swap_ack", swap_ack, 1'b1);
      chk("swap_active_count", active_count, DW'(act_n));
      chk("swap_shadow_count", shadow_count, '0);
      chk("swap_ovf_clear", wr_overflow, 1'b0);
      tick();
      chk("swap_ack_pulse", swap_ack, 1'b0);
   endtask
   task automatic read(input int a);
      sb.push_back({act_m[a], 1'b0});
      rd_en   = 1'b1;
      rd_addr = 8'(a);
      tick();
      rd_en = 1'b0;
   endtask
   task automatic stream(input int swap_at);
      int n;
      int k;
      n = act_n;
      for (int i = 0; i < n; i++) sb.push_back({act_m[i], i == n - 1});
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      if (n == 0) begin
         chk("empty_done", stream_done, 1'b1);
         chk("empty_busy", stream_busy, 1'b0);
         tick();
         chk("empty_done_pulse", stream_done, 1'b0);
         tick();
      end else begin
         chk("busy_start", stream_busy, 1'b1);
         k = 0;
         while (!rd_last && k < n + 4) begin
            swap_req = (k == swap_at);
            tick();
            k++;
         end
         swap_req = 1'b0;
         chk("last_seen", rd_last, 1'b1);
         chk("last_cycle", DW'(k), DW'(n));
         chk("done_with_last", stream_done, 1'b1);
         chk("busy_on_last", stream_busy, 1'b1);
         chk("ack_deferred", swap_ack, 1'b0);
         tick();
         chk("busy_after", stream_busy, 1'b0);
         chk("done_pulse", stream_done, 1'b0);
         if (swap_at >= 0) begin
            model_swap();
            chk("deferred_ack", swap_ack, 1'b1);
            chk("deferred_active", active_count, DW'(act_n));
         end
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [DW-1:0] d;
      #2;
      chk("rst_rd_data", rd_data, '0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_busy", stream_busy, 1'b0);
      chk("rst_done", stream_done, 1'b0);
      chk("rst_full", wr_full, 1'b0);
      chk("rst_ovf", wr_overflow, 1'b0);
      chk("rst_ack", swap_ack, 1'b0);
      chk("rst_active", active_count, '0);
      chk("rst_shadow", shadow_count, '0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      // A,B,C then swap and stream
      for (int i = 0; i < 3; i++) write(rnd());
      swap(1'b0, '0);
      stream(-1);
      // fill to capacity, overflow, swap, stream all
      for (int i = 0; i < PN; i++) write(rnd());
      chk("full_set", wr_full, 1'b1);
      chk("ovf_not_yet", wr_overflow, 1'b0);
      write(rnd());
      chk("full_count_hold", shadow_count, DW'(PN));
      chk("ovf_set", wr_overflow, 1'b1);
      swap(1'b0, '0);
      chk("full_clear", wr_full, 1'b0);
      stream(-1);
      read(0);
      read(PN - 1);
      // 5-particle stream with a swap request at beat 1
      for (int i = 0; i < 5; i++) write(rnd());
      swap(1'b0, '0);
      write(rnd());
      write(rnd());
      stream(1);
      tick();
      chk("after_deferred_shadow", shadow_count, '0);
      // write coinciding with the swap edge
      write(rnd());
      write(rnd());
      d = rnd();
      swap(1'b1, d);
      chk("swap_write_count", active_count, DW'(3));
      read(2);
      read(0);
      tick();
      // empty active bank stream
      swap(1'b0, '0);
      chk("empty_active", active_count, '0);
      stream(-1);
      // reset in the middle of a stream
      for (int i = 0; i < 4; i++) write(rnd());
      swap(1'b0, '0);
      write(rnd());
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      tick();
      chk("mid_busy", stream_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mrst_rd_valid", rd_valid, 1'b0);
      chk("mrst_rd_data", rd_data, '0);
      chk("mrst_rd_last", rd_last, 1'b0);
      chk("mrst_busy", stream_busy, 1'b0);
      chk("mrst_active", active_count, '0);
      chk("mrst_shadow", shadow_count, '0);
      #2 rst_n = 1'b1;
      act_n = 0;
      shd_n = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_idle", rd_valid, 1'b0);
      end
      write(rnd());
      swap(1'b0, '0);
      read(0);
      tick();
      tick();
      chk("sb_empty", DW'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
